data_compare_seq: RTL and testbench

Parametrised, multi-cycle magnitude comparator that extends the 4-bit cascadable comparator to WIDTH-bit operands. It compares CHUNK bits per clock, MSB slice first, and exits early on the first unequal slice. When the operands are fully equal, the result comes from the 3-bit cascade input. The block sits in the datapath where wide operands are compared under a start/done handshake, and its cascade input and result encoding match the existing comparator.

---
 rtl/data_compare_seq_if.sv | 22 ++
 rtl/data_compare_seq.sv | 114 +++++++++++
 tb/tb_data_compare_seq.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_compare_seq_if.sv
// Start/done handshake bundle for the multi-cycle wide magnitude comparator.
interface data_compare_seq_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       comp;  // cascade input {gt_in, eq_in, lt_in}
    logic [2:0]       o;     // result {gt, eq, lt}
    logic             done;
    logic             busy;

    modport master (
        output start, a, b, comp,
        input  o, done, busy
    );

    modport slave (
        input  start, a, b, comp,
        output o, done, busy
    );
endinterface

// File: rtl/data_compare_seq.sv
// Multi-cycle WIDTH-bit magnitude comparator: walks CHUNK-bit slices MSB first,
// exits on the first unequal slice, falls back to the cascade input when all equal.
module data_compare_seq #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned CHUNK  = 4,
    parameter bit          SIGNED = 1'b0
) (
    input logic               clk,
    input logic               rst_n,
    data_compare_seq_if.slave bus_io
);
    localparam int unsigned N    = WIDTH / CHUNK;
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

    // Flipping the sign bit maps two's-complement onto offset binary, so the
    // same unsigned slice compare works for both modes.
    localparam logic [WIDTH-1:0] SignMask =
        SIGNED ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

    typedef enum logic [0:0] {StIdle, StCmp} state_e;

    state_e           state_q, state_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       comp_q;
    logic [2:0]       o_q, o_d;
    logic             done_q, done_d;
    logic             load;
    logic [CHUNK-1:0] a_slice, b_slice;
    logic [2:0]       cascade;

    // Select the current slice, MSB slice at idx 0.
    always_comb begin
        a_slice = a_q[(WIDTH - 1) - (int'(idx_q) * CHUNK) -: CHUNK];
        b_slice = b_q[(WIDTH - 1) - (int'(idx_q) * CHUNK) -: CHUNK];
    end

    // Cascade decode with priority eq > gt > lt; keeps the result one-hot.
    always_comb begin
        cascade = 3'b000;
        if (comp_q[1]) begin
            cascade = 3'b010;
        end else if (comp_q[2]) begin
            cascade = 3'b100;
        end else if (comp_q[0]) begin
            cascade = 3'b001;
        end
    end

    // Next-state, slice stepping and result selection.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        o_d     = o_q;
        done_d  = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = StCmp;
                end
            end
            StCmp: begin
                if (a_slice != b_slice) begin
                    o_d     = (a_slice > b_slice) ? 3'b100 : 3'b001;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (idx_q == LastIdx) begin
                    o_d     = cascade;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            o_q     <= 3'b000;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            o_q     <= o_d;
            done_q  <= done_d;
        end
    end

    // Operand capture at start acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            comp_q <= 3'b000;
        end else if (load) begin
            a_q    <= bus_io.a ^ SignMask;
            b_q    <= bus_io.b ^ SignMask;
            comp_q <= bus_io.comp;
        end
    end

    assign bus_io.o    = o_q;
    assign bus_io.done = done_q;
    assign bus_io.busy = (state_q == StCmp);
endmodule

// File: tb/tb_data_compare_seq.sv
// Bench for data_compare_seq: unsigned and signed instances, directed cases
// plus random operands checked against an arithmetic reference model.
module tb_data_compare_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    data_compare_seq_if #(.WIDTH(16)) u_if ();
    data_compare_seq_if #(.WIDTH(16)) s_if ();

    data_compare_seq #(.WIDTH(16), .CHUNK(4), .SIGNED(1'b0)) dut_u (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (u_if.slave)
    );

    data_compare_seq #(.WIDTH(16), .CHUNK(4), .SIGNED(1'b1)) dut_s (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (s_if.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: whole-word arithmetic compare; cascade only on full equality.
    function automatic logic [2:0] model_o(input bit sg, input logic [15:0] a,
                                           input logic [15:0] b, input logic [2:0] c);
        if (a == b) begin
            if (c[1]) return 3'b010;
            if (c[2]) return 3'b100;
            if (c[0]) return 3'b001;
            return 3'b000;
        end
        if (sg) return ($signed(a) > $signed(b)) ? 3'b100 : 3'b001;
        return (a > b) ? 3'b100 : 3'b001;
    endfunction

    // Latency: 4-bit group holding the highest differing bit, counted from the MSB.
    function automatic int model_k(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] d;
        d = a ^ b;
        if (d == 16'h0) return 4;
        for (int p = 15; p >= 0; p--) begin
            if (d[p]) return (15 - p) / 4 + 1;
        end
        return 4;
    endfunction

    function automatic logic [2:0] get_o(input bit sg);
        return sg ? s_if.o : u_if.o;
    endfunction

    function automatic logic get_done(input bit sg);
        return sg ? s_if.done : u_if.done;
    endfunction

    function automatic logic get_busy(input bit sg);
        return sg ? s_if.busy : u_if.busy;
    endfunction

    task automatic drive(input bit sg, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] c, input logic st);
        if (sg) begin
            s_if.a = a; s_if.b = b; s_if.comp = c; s_if.start = st;
        end else begin
            u_if.a = a; u_if.b = b; u_if.comp = c; u_if.start = st;
        end
    endtask

    task automatic set_start(input bit sg, input logic st);
        if (sg) s_if.start = st;
        else    u_if.start = st;
    endtask

    task automatic launch(input bit sg, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] c);
        @(negedge clk);
        drive(sg, a, b, c, 1'b1);
        @(posedge clk);
        #1;
        set_start(sg, 1'b0);
        check("busy_after_start", 32'(get_busy(sg)), 32'd1);
    endtask

    task automatic wait_result(input bit sg, input logic [15:0] a, input logic [15:0] b,
                               input logic [2:0] c, input int already);
        int cyc;
        cyc = already;
        while (!get_done(sg) && cyc < 8) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("done_seen", 32'(get_done(sg)), 32'd1);
        check("latency", 32'(cyc), 32'(model_k(a, b)));
        check("result", 32'(get_o(sg)), 32'(model_o(sg, a, b, c)));
        check("busy_at_done", 32'(get_busy(sg)), 32'd0);
    endtask

    task automatic drop(input bit sg, input logic [2:0] exp_o);
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(get_done(sg)), 32'd0);
        check("o_held", 32'(get_o(sg)), 32'(exp_o));
    endtask

    task automatic cmp(input bit sg, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] c);
        launch(sg, a, b, c);
        wait_result(sg, a, b, c, 0);
        drop(sg, model_o(sg, a, b, c));
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic [2:0]  rc;
        int          r;

        drive(1'b0, 16'h0, 16'h0, 3'b000, 1'b0);
        drive(1'b1, 16'h0, 16'h0, 3'b000, 1'b0);

        // Reset held with start asserted: nothing may happen.
        rst_n = 1'b0;
        set_start(1'b0, 1'b1);
        set_start(1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("rst_o", 32'(u_if.o), 32'd0);
        check("rst_done", 32'(u_if.done), 32'd0);
        check("rst_busy", 32'(u_if.busy), 32'd0);
        check("rst_busy_s", 32'(s_if.busy), 32'd0);
        @(negedge clk);
        set_start(1'b0, 1'b0);
        set_start(1'b1, 1'b0);
        rst_n = 1'b1;

        // Full-equal operands resolved by the cascade input.
        cmp(1'b0, 16'h1234, 16'h1234, 3'b010);
        cmp(1'b0, 16'h1234, 16'h1234, 3'b100);
        cmp(1'b0, 16'h1234, 16'h1234, 3'b001);
        cmp(1'b0, 16'h1234, 16'h1234, 3'b000);
        cmp(1'b0, 16'h1234, 16'h1234, 3'b111);

        // Early exit at different slices.
        cmp(1'b0, 16'h8000, 16'h7FFF, 3'b000);
        cmp(1'b0, 16'h1235, 16'h1234, 3'b001);
        cmp(1'b0, 16'h1204, 16'h1234, 3'b010);

        // Signed instance.
        cmp(1'b1, 16'h8000, 16'h7FFF, 3'b000);
        cmp(1'b1, 16'hFFFF, 16'hFFFE, 3'b000);
        cmp(1'b1, 16'h1234, 16'h1234, 3'b100);

        // Start during busy is ignored.
        launch(1'b0, 16'h1234, 16'h1234, 3'b100);
        @(negedge clk);
        drive(1'b0, 16'h0001, 16'hFFFF, 3'b001, 1'b1);
        @(posedge clk);
        #1;
        set_start(1'b0, 1'b0);
        wait_result(1'b0, 16'h1234, 16'h1234, 3'b100, 1);
        drop(1'b0, 3'b100);

        // Start in the done cycle launches a second comparison.
        launch(1'b0, 16'h1235, 16'h1234, 3'b001);
        wait_result(1'b0, 16'h1235, 16'h1234, 3'b001, 0);
        drive(1'b0, 16'h7FFF, 16'h8000, 3'b000, 1'b1);
        @(posedge clk);
        #1;
        set_start(1'b0, 1'b0);
        check("b2b_busy", 32'(u_if.busy), 32'd1);
        check("b2b_done_low", 32'(u_if.done), 32'd0);
        wait_result(1'b0, 16'h7FFF, 16'h8000, 3'b000, 0);
        drop(1'b0, 3'b001);

        // Reset in the middle of a comparison.
        launch(1'b0, 16'hAAAA, 16'hAAAA, 3'b010);
        @(posedge clk);
        @(posedge clk);
        #3;
        set_start(1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_o", 32'(u_if.o), 32'd0);
        check("midrst_done", 32'(u_if.done), 32'd0);
        check("midrst_busy", 32'(u_if.busy), 32'd0);
        check("midrst_o_s", 32'(s_if.o), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("midrst_no_done", 32'(u_if.done), 32'd0);
        end
        check("midrst_o_stays", 32'(u_if.o), 32'd0);
        @(negedge clk);
        set_start(1'b0, 1'b0);
        rst_n = 1'b1;
        cmp(1'b0, 16'hAAAA, 16'hAAAA, 3'b010);

        // Random operands, biased toward shared prefixes to exercise every latency.
        for (int i = 0; i < 40; i++) begin
            for (int s = 0; s < 2; s++) begin
                ra = 16'($urandom);
                r  = $urandom_range(0, 3);
                if (r == 0) begin
                    rb = ra;
                end else if (r == 1) begin
                    rb = 16'($urandom);
                end else begin
                    rb = ra ^ (16'($urandom_range(1, 15)) << (4 * $urandom_range(0, 3)));
                end
                rc = 3'($urandom);
                cmp(s[0], ra, rb, rc);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
